multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one register file and one unified instruction/data memory, reused over several cycles per instruction. Every datapath enable and mux select comes from this block, decoded from the current state and the latched instruction fields. It replaces the single-cycle combinational control decoder when the CPU is built in multi-cycle form.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  datapath clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 allows instruction issue, 0 stops issue at the next fetch boundary
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; used only when opcode=000000
- zero  in  1  ALU zero flag
- pc_en  out  1  PC write enable (combinational, see Operation)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write address select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs data
- alu_src_b  out  2  ALU B select: 0 = rt data, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- alu_ctrl  out  3  ALU operation
- pc_src  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target
- halted  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  count of instructions fetched

## Operation
- State register (4 bits): IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, RWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT.
- All outputs except pc_en are Moore outputs, decoded from the state register only. Every signal not listed for a state is 0.
- Outputs by state:
  - IDLE: all 0.
  - FETCH: ir_write=1, alu_src_b=1, alu_ctrl=ADD, pc_src=0, PC write. Performs PC <= PC+4.
  - DECODE: alu_src_b=3, alu_ctrl=ADD. Precomputes the branch target.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=2, alu_ctrl=ADD.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - RTYPE: alu_src_a=1, alu_ctrl decoded from funct.
  - RWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_ctrl=SUB, pc_src=1, conditional PC write.
  - JUMP: pc_src=2, PC write.
- pc_en = (FETCH | JUMP) | (BRANCH & zero).
- Transitions:
  - IDLE→FETCH when run=1.
  - FETCH→DECODE.
  - DECODE by opcode: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → RTYPE; 000100 (beq) → BRANCH; 000010 (j) → JUMP; 001000 (addi) → ADDIEX; anything else → HALT.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB; RTYPE→RWB; ADDIEX→ADDIWB.
  - The terminal states MEMWB, MEMWR, RWB, BRANCH, JUMP and ADDIWB go to FETCH if run=1, else IDLE.
  - HALT holds until rst.
- funct decode: 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT. Any other funct in RTYPE forces the next state to HALT instead of RWB; reg_write stays 0.
- retired increments by 1 on every cycle spent in FETCH. It wraps modulo 2^CNT_W.
- halted = (state==HALT).

## Timing
- rst asserted, at any time and in any state: state=IDLE, retired=0. All outputs go to 0 immediately (asynchronous).
- After rst is released, the first FETCH occurs one cycle after run is sampled 1.
- Cycles per instruction, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Dropping run mid-instruction does not abort it. The instruction completes, then the FSM parks in IDLE. Raising run again resumes at FETCH the next cycle.
- pc_en follows zero combinationally in BRANCH, with zero-cycle latency.
- opcode and funct are sampled only in DECODE and RTYPE. Changes in other states are ignored.

## Structure
- Shared package mips_pkg holds:
  - state encoding enum state_t;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - funct constants;
  - ALU codes ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111 (the same ALU codes the ALU module decodes);
  - alu_src_b and pc_src select constants.
- One sub-module, alu_decode: combinational funct → {alu_ctrl, legal}. The FSM and output decode stay in multicycle_control.

## Test plan
- Reset and run gating: rst=1 for 2 cycles, run=0 → all outputs 0 and retired=0. Raise run → FETCH on the next cycle with ir_write=1, pc_en=1, alu_src_b=1.
- lw (opcode=100011) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, with iord=1 in MEMRD, mem_to_reg=1 and reg_write=1 in MEMWB, then FETCH. retired=1 after the first FETCH and 2 after the second.
- R-type sub (funct=100010) → alu_ctrl=110 in RTYPE, reg_dst=1 and reg_write=1 in RWB, 4 cycles total. funct=000111 → HALT and halted=1, with no reg_write pulse.
- beq with zero=1 → pc_en=1 and pc_src=1 in BRANCH. With zero=0 → pc_en=0. Both cases return to FETCH after 3 cycles.
- run dropped during MEMADR of sw → MEMWR still produces mem_write=1, then IDLE with outputs 0. Raise run → FETCH the next cycle.
- Opcode 111111 → HALT; halted stays 1 for 10 cycles regardless of run. Assert rst mid-HALT → IDLE and halted=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encoding,
// instruction field constants, ALU operation codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// R-type function-field decoder: maps funct to an ALU operation code and
// flags whether the funct is one the datapath supports.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the shared MIPS datapath: sequences fetch,
// decode, execute, memory and write-back, and counts fetched instructions.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    logic             is_store_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [2:0]       rtype_alu_ctrl;
    logic             funct_legal;

    alu_decode u_alu_decode (
        .funct    (funct),
        .alu_ctrl (rtype_alu_ctrl),
        .legal    (funct_legal)
    );

    // The opcode is only trusted in DECODE, so the lw/sw choice is kept here
    // for the MEMADR branch a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            is_store_reg <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                is_store_reg <= (opcode == OP_SW);
            end
            if (state_reg == S_FETCH) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR: state_next = is_store_reg ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = S_MEMWB;
            S_RTYPE:  state_next = funct_legal ? S_RWB : S_HALT;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB:
                      state_next = run ? S_FETCH : S_IDLE;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_ctrl   = ALU_AND;
        pc_src     = PC_SRC_ALU;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                pc_src    = PC_SRC_ALU;
                pc_en     = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_ctrl  = rtype_alu_ctrl;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            // Branch resolves combinationally on the ALU zero flag.
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = PC_SRC_JUMP;
                pc_en  = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign retired = retired_reg;

endmodule
